// File: rtl/mem_ctrl.sv
// Purpose: byte-wide RAM/IO port shared by the fetch byte stream and LSB 1/2/4-byte loads/stores; LSB wins.
// Latency: fetch byte 1 cycle after if_rdy; load done N+2 cycles, store done N+1 cycles after the request cycle.
// Backpressure: rdy_in low freezes state and bus; IO stores issue a byte only while io_buffer_full is low.
// Ports: clk_in/rst_in (async, active-high), rdy_in global enable, rob_clear load abort;
//        if_en/if_addr -> if_rdy/if_byte fetch port; lsb_req/we/addr/len/wdata -> lsb_done/lsb_rdata LSB port;
//        mem_din/mem_dout/mem_a/mem_wr RAM/IO bus; io_buffer_full/io_writing IO store pacing.
module mem_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_MASK = 32'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [7:0]        if_byte,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic              io_writing,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, LD = 2'd1, ST = 2'd2} state_t;

  // Request latched on acceptance so the LSB may drop or change its inputs mid-operation.
  typedef struct packed {
    logic              we;
    logic              io;
    logic [2:0]        len;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
  } req_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;      // 1-based cycle index inside LD/ST
  req_t              req_q;
  logic [31:0]       ld_data;
  logic [ADDR_W-1:0] last_a;            // address presented last cycle

  logic              act;
  logic [2:0]        len_norm;
  logic [ADDR_W-1:0] cur_a;
  logic [1:0]        cap_idx, wr_idx;
  logic              ld_issue, ld_capture, st_blocked, st_issue;

  assign act        = rdy_in & ~rst_in;
  assign len_norm   = (lsb_len == 3'd1 || lsb_len == 3'd2) ? lsb_len : 3'd4;
  assign cur_a      = req_q.base + ADDR_W'(cnt - 3'd1);
  // Read data lags the issued address by one cycle, so cycle k captures byte k-2.
  assign cap_idx    = 2'(cnt - 3'd2);
  assign wr_idx     = 2'(cnt - 3'd1);
  assign ld_issue   = (state == LD) && (cnt <= req_q.len) && !rob_clear;
  assign ld_capture = (state == LD) && (cnt >= 3'd2) && (cnt <= req_q.len + 3'd1) && !rob_clear;
  assign st_blocked = req_q.io && io_buffer_full;
  assign st_issue   = (state == ST) && (cnt <= req_q.len) && !st_blocked;

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      ld_data <= '0;
      last_a  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // While frozen mem_a already equals last_a, so the RAM keeps reading the pending byte.
      last_a <= mem_a;
      if (act && state == IDLE && lsb_req) begin
        req_q.we    <= lsb_we;
        req_q.io    <= (lsb_addr & IO_MASK) == IO_MASK;
        req_q.len   <= len_norm;
        req_q.base  <= lsb_addr;
        req_q.wdata <= lsb_wdata;
        ld_data     <= '0;
      end
      if (act && ld_capture) begin
        ld_data[{cap_idx, 3'b000} +: 8] <= mem_din;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (act) begin
      case (state)
        IDLE: begin
          if (lsb_req) begin
            state_nxt = lsb_we ? ST : LD;
            cnt_nxt   = 3'd1;
          end
        end
        LD: begin
          if (rob_clear || cnt == req_q.len + 3'd2) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        ST: begin
          if (cnt == req_q.len + 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (!st_blocked) begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    if_rdy   = 1'b0;
    mem_a    = last_a;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    lsb_done = 1'b0;
    if (act) begin
      case (state)
        IDLE: begin
          if (!lsb_req && if_en && !rob_clear) begin
            if_rdy = 1'b1;
            mem_a  = if_addr;
          end
        end
        LD: begin
          if (ld_issue) mem_a = cur_a;
          lsb_done = !rob_clear && (cnt == req_q.len + 3'd2);
        end
        ST: begin
          if (st_issue) begin
            mem_wr   = 1'b1;
            mem_a    = cur_a;
            mem_dout = req_q.wdata[{wr_idx, 3'b000} +: 8];
          end
          lsb_done = (cnt == req_q.len + 3'd1);
        end
        default: ;
      endcase
    end
  end

  assign io_writing = (state == ST) && req_q.io;
  assign lsb_rdata  = (lsb_done && state == LD) ? ld_data : 32'h0;
  assign if_byte    = rst_in ? 8'h00 : mem_din;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, if_en, lsb_req, lsb_we, io_buffer_full;
  logic [31:0] if_addr, lsb_addr, lsb_wdata;
  logic [2:0]  lsb_len;
  logic        if_rdy, lsb_done, io_writing, mem_wr;
  logic [7:0]  if_byte, mem_dout;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] lsb_rdata, mem_a;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_byte(if_byte),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .io_writing(io_writing), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Unwritten bytes read as addr[7:0] ^ 0xA5.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Environment RAM with one-cycle read latency.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk_in) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  // Reference model state: transaction phase, expected bytes from a shadow memory.
  logic [7:0]  shadow [logic [31:0]];
  int          checks = 0, errors = 0;
  int          m_st = 0, m_step = 0, m_len = 0, m_acc = 0, acc_seen = 0;
  logic        m_io = 1'b0, f_pend = 1'b0;
  logic [31:0] m_base = '0, m_wdata = '0, m_exp = '0, m_last_a = '0;
  logic [7:0]  f_byte = '0;

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_byte(a);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called once per cycle with inputs settled: check outputs, then advance the model.
  task automatic model_step();
    logic        e_if_rdy, e_wr, e_done, e_io, chk_a, chk_byte, ld_fin;
    logic [31:0] e_a;
    logic [7:0]  e_d, e_byte;
    if (rst_in) begin
      cmp("rst_if_rdy", if_rdy, 0);     cmp("rst_if_byte", if_byte, 0);
      cmp("rst_lsb_done", lsb_done, 0); cmp("rst_lsb_rdata", lsb_rdata, 0);
      cmp("rst_io_writing", io_writing, 0); cmp("rst_mem_wr", mem_wr, 0);
      cmp("rst_mem_dout", mem_dout, 0); cmp("rst_mem_a", mem_a, 0);
      m_st = 0; f_pend = 1'b0; m_last_a = '0;
      return;
    end
    chk_byte = f_pend; e_byte = f_byte; f_pend = 1'b0;
    e_if_rdy = 0; e_wr = 0; e_done = 0; e_io = 0; chk_a = 0; ld_fin = 0;
    e_a = '0; e_d = '0;
    case (m_st)
      0: if (rdy_in) begin
        if (lsb_req) begin
          m_st = lsb_we ? 2 : 1;
          m_base = lsb_addr; m_wdata = lsb_wdata; m_step = 1; m_acc++;
          m_len = (lsb_len == 3'd1 || lsb_len == 3'd2) ? int'(lsb_len) : 4;
          m_io = (lsb_addr & 32'h30000) == 32'h30000;
          m_exp = '0;
          for (int i = 0; i < m_len; i++) m_exp[8*i +: 8] = sh_rd(m_base + 32'(i));
        end else if (if_en && !rob_clear) begin
          e_if_rdy = 1; chk_a = 1; e_a = if_addr;
          f_pend = 1'b1; f_byte = sh_rd(if_addr);
        end
      end
      1: if (rdy_in) begin
        if (rob_clear) m_st = 0;
        else if (m_step == m_len + 2) begin e_done = 1; ld_fin = 1; m_st = 0; end
        else begin
          if (m_step <= m_len) begin chk_a = 1; e_a = m_base + 32'(m_step - 1); end
          m_step++;
        end
      end
      default: begin
        e_io = m_io;
        if (rdy_in) begin
          if (m_step == m_len + 1) begin e_done = 1; m_st = 0; end
          else if (!(m_io && io_buffer_full)) begin
            e_wr = 1; chk_a = 1; e_a = m_base + 32'(m_step - 1);
            e_d = m_wdata[8*(m_step-1) +: 8];
            shadow[e_a] = e_d;
            m_step++;
          end
        end
      end
    endcase
    cmp("if_rdy", if_rdy, e_if_rdy);
    cmp("mem_wr", mem_wr, e_wr);
    cmp("lsb_done", lsb_done, e_done);
    cmp("io_writing", io_writing, e_io);
    cmp("mem_dout", mem_dout, e_d);
    if (chk_a) cmp("mem_a", mem_a, e_a);
    else if (!rdy_in) cmp("mem_a_hold", mem_a, m_last_a);
    if (chk_a) m_last_a = e_a;
    if (ld_fin) cmp("lsb_rdata", lsb_rdata, m_exp);
    if (chk_byte) cmp("if_byte", if_byte, e_byte);
  endtask

  task automatic settle();
    #3;
    model_step();
  endtask

  task automatic advance();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet();
    rdy_in = 1; rob_clear = 0; if_en = 0; if_addr = '0; lsb_req = 0; lsb_we = 0;
    lsb_addr = '0; lsb_len = '0; lsb_wdata = '0; io_buffer_full = 0;
  endtask

  task automatic start_req(input logic we, input logic [31:0] a, input logic [2:0] len, input logic [31:0] wd);
    lsb_req = 1; lsb_we = we; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
  endtask

  logic [7:0]  t1_exp [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
  logic [31:0] t3_a   [2] = '{32'h200, 32'h201};
  logic [7:0]  t3_d   [2] = '{8'hEF, 8'hBE};
  logic [31:0] seq_a = '0;
  int          r;

  initial begin
    quiet();
    rst_in = 1; if_en = 1; if_addr = 32'h5;
    settle();
    cmp("lit_rst_if_rdy", if_rdy, 0);
    advance(); settle(); advance();
    rst_in = 0; quiet();
    settle(); advance();

    // Fetch stream over addresses 0..3.
    if_en = 1;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) if_addr = 32'(c - 1); else if_en = 0;
      settle();
      if (c <= 4) cmp("lit_fetch_rdy", if_rdy, 1);
      if (c >= 2) cmp("lit_fetch_byte", if_byte, t1_exp[c-2]);
      advance();
    end

    // Place 11,22,33,44 at 0x100 through a 4-byte store.
    start_req(1, 32'h100, 3'd4, 32'h4433_2211);
    for (int c = 0; c <= 5; c++) begin
      settle();
      if (c == 5) cmp("lit_prep_done", lsb_done, 1);
      advance();
    end
    quiet();

    // 4-byte load; fetch requested throughout must not be granted.
    start_req(0, 32'h100, 3'd4, '0); if_en = 1; if_addr = 32'h10;
    for (int c = 0; c <= 6; c++) begin
      settle();
      if (c <= 5) begin cmp("lit_ld_if_rdy", if_rdy, 0); cmp("lit_ld_early_done", lsb_done, 0); end
      else begin cmp("lit_ld_done", lsb_done, 1); cmp("lit_ld_rdata", lsb_rdata, 32'h4433_2211); end
      advance();
    end
    quiet();

    // 2-byte store of 0xBEEF to 0x200.
    start_req(1, 32'h200, 3'd2, 32'h0000_BEEF);
    for (int c = 0; c <= 3; c++) begin
      settle();
      if (c == 1 || c == 2) begin
        cmp("lit_st_wr", mem_wr, 1); cmp("lit_st_a", mem_a, t3_a[c-1]); cmp("lit_st_d", mem_dout, t3_d[c-1]);
      end
      if (c == 3) begin cmp("lit_st_done", lsb_done, 1); cmp("lit_st_wr_off", mem_wr, 0); end
      advance();
    end
    quiet();

    // IO store paced by io_buffer_full; request dropped after acceptance.
    start_req(1, 32'h30000, 3'd1, 32'h41); io_buffer_full = 1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) lsb_req = 0;
      if (c == 4) io_buffer_full = 0;
      settle();
      if (c >= 1 && c <= 3) begin cmp("lit_io_stall_wr", mem_wr, 0); cmp("lit_io_writing", io_writing, 1); end
      if (c == 4) begin cmp("lit_io_wr", mem_wr, 1); cmp("lit_io_d", mem_dout, 8'h41); cmp("lit_io_a", mem_a, 32'h30000); end
      if (c == 5) begin cmp("lit_io_done", lsb_done, 1); cmp("lit_io_writing_done", io_writing, 1); end
      if (c == 6) cmp("lit_io_writing_off", io_writing, 0);
      advance();
    end
    quiet();

    // rob_clear in cycle 2 of a 4-byte load.
    start_req(0, 32'h100, 3'd4, '0); if_en = 1; if_addr = 32'h100;
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) begin rob_clear = 1; lsb_req = 0; end
      if (c == 3) rob_clear = 0;
      settle();
      if (c >= 2) cmp("lit_abort_no_done", lsb_done, 0);
      if (c == 2) cmp("lit_abort_if_rdy", if_rdy, 0);
      if (c == 3) cmp("lit_abort_idle", if_rdy, 1);
      if (c == 4) cmp("lit_abort_fetch", if_byte, 8'h11);
      advance();
    end
    quiet();

    // rdy_in low for cycles 3 and 4 of a 4-byte load.
    start_req(0, 32'h100, 3'd4, '0);
    for (int c = 0; c <= 8; c++) begin
      rdy_in = !(c == 3 || c == 4);
      settle();
      if (c == 3 || c == 4) cmp("lit_stall_a", mem_a, 32'h101);
      if (c <= 7) cmp("lit_stall_no_done", lsb_done, 0);
      else begin cmp("lit_stall_done", lsb_done, 1); cmp("lit_stall_rdata", lsb_rdata, 32'h4433_2211); end
      advance();
    end
    quiet();

    // Reset asserted in the middle of a store.
    start_req(1, 32'h300, 3'd4, 32'hCAFE_F00D); if_en = 1; if_addr = 32'h77;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) rst_in = 1;
      if (c == 3) begin rst_in = 0; lsb_req = 0; if_addr = 32'h300; end
      if (c == 4) if_en = 0;
      settle();
      if (c == 2) begin cmp("lit_rst_mid_wr", mem_wr, 0); cmp("lit_rst_mid_a", mem_a, 0); cmp("lit_rst_mid_io", io_writing, 0); end
      if (c == 3) cmp("lit_rst_idle", if_rdy, 1);
      if (c == 4) cmp("lit_rst_kept_byte", if_byte, 8'h0D);
      advance();
    end
    quiet();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rdy_in         = $urandom_range(0, 99) < 85;
      io_buffer_full = $urandom_range(0, 99) < 40;
      if_en          = $urandom_range(0, 99) < 70;
      if ($urandom_range(0, 1) == 1) begin if_addr = seq_a; seq_a = (seq_a + 1) & 32'hFF; end
      else if_addr = $urandom_range(0, 255);
      rob_clear = 0;
      if (lsb_req) begin
        if (m_acc != acc_seen) begin
          if (m_st == 0) lsb_req = 0;
          else if ($urandom_range(0, 99) < 15) lsb_req = 0;
        end
      end else if (m_st == 0 && $urandom_range(0, 99) < 20) begin
        r = $urandom_range(0, 9);
        if (r < 6)      lsb_addr = $urandom_range(0, 255);
        else if (r < 8) lsb_addr = 32'h30000 + $urandom_range(0, 3);
        else            lsb_addr = 32'hFFFF_FFFC + $urandom_range(0, 3);
        lsb_req = 1; lsb_we = $urandom_range(0, 1) == 1;
        lsb_len = 3'($urandom_range(0, 7)); lsb_wdata = $urandom;
        acc_seen = m_acc;
      end
      if (!(m_st == 0 && lsb_req) && $urandom_range(0, 99) < 4) rob_clear = 1;
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
